// File: rtl/axi_rd_arbiter_pkg.sv
// Shared constants for the AXI read-path arbiter: FSM encodings, burst type
// and the one-hot grant values used by the top and by the grant picker.
package axi_rd_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } arb_state_e;

    localparam logic [1:0] INCR     = 2'b01;
    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_IF   = 2'b01;
    localparam logic [1:0] GNT_MEM  = 2'b10;

endpackage

// File: rtl/axi_rd_arbiter_pick.sv
// Next-grant selection for the read arbiter, including the policy state.
// Build option AXI_RD_ARB_RR_EN: defined selects round-robin on contention
// (tracks last_grant); undefined selects fixed MEM priority with a saturating
// starvation counter that forces IF after STARVE_MAX consecutive MEM wins.
module rd_arb_pick
    import axi_rd_arbiter_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       if_req_i,
    input  logic       mem_req_i,
    input  logic       pick_en_i,   // high in the cycle the FSM latches pick_o
    output logic [1:0] pick_o
);

`ifdef AXI_RD_ARB_RR_EN

    logic [1:0] last_grant_q, last_grant_d;

    // Round-robin: on contention the master that did not win last time goes.
    always_comb begin
        pick_o       = GNT_NONE;
        last_grant_d = last_grant_q;
        if (if_req_i && mem_req_i) begin
            pick_o = (last_grant_q == GNT_MEM) ? GNT_IF : GNT_MEM;
        end else if (if_req_i) begin
            pick_o = GNT_IF;
        end else if (mem_req_i) begin
            pick_o = GNT_MEM;
        end
        if (pick_en_i && (pick_o != GNT_NONE)) begin
            last_grant_d = pick_o;
        end
    end

    // Remember the most recent winner; reset favours IF first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= GNT_MEM;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

`else

    localparam int CW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);

    logic [CW-1:0] starve_q, starve_d;

    // Fixed MEM priority; IF is forced once it has lost STARVE_MAX times in a row.
    always_comb begin
        pick_o   = GNT_NONE;
        starve_d = starve_q;
        if (if_req_i && mem_req_i) begin
            pick_o = (starve_q == STARVE_LIM) ? GNT_IF : GNT_MEM;
        end else if (if_req_i) begin
            pick_o = GNT_IF;
        end else if (mem_req_i) begin
            pick_o = GNT_MEM;
        end
        if (pick_en_i) begin
            if (pick_o == GNT_IF) begin
                starve_d = '0;
            end else if ((pick_o == GNT_MEM) && if_req_i && (starve_q != STARVE_LIM)) begin
                starve_d = starve_q + 1'b1;
            end
        end
    end

    // Starvation counter register; saturates at STARVE_LIM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end

`endif

endmodule

// File: rtl/axi_rd_arbiter.sv
// Shares one AXI read path (AR + R) between instruction fetch (IF) and
// load/store (MEM). One burst outstanding; R beats are routed by the
// registered grant until RLAST. Policy selected by AXI_RD_ARB_RR_EN
// (see rd_arb_pick). Handshakes: a transfer occurs on a channel in a cycle
// where valid and ready are both high; the arbiter never alters a payload
// while its valid is high, it only passes valid/ready through for the owner.
module axi_rd_arbiter
    import axi_rd_arbiter_pkg::*;
#(
    parameter int ADDR_W     = 64,
    parameter int DATA_W     = 64,
    parameter int ID_W       = 4,
    parameter int IF_ID      = 0,
    parameter int MEM_ID     = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_arvalid,
    output logic              if_arready,
    input  logic [ADDR_W-1:0] if_araddr,
    input  logic [7:0]        if_arlen,
    input  logic [2:0]        if_arsize,
    output logic              if_rvalid,
    input  logic              if_rready,
    output logic [DATA_W-1:0] if_rdata,
    output logic [1:0]        if_rresp,
    output logic              if_rlast,
    input  logic              mem_arvalid,
    output logic              mem_arready,
    input  logic [ADDR_W-1:0] mem_araddr,
    input  logic [7:0]        mem_arlen,
    input  logic [2:0]        mem_arsize,
    output logic              mem_rvalid,
    input  logic              mem_rready,
    output logic [DATA_W-1:0] mem_rdata,
    output logic [1:0]        mem_rresp,
    output logic              mem_rlast,
    output logic              axi_arvalid,
    input  logic              axi_arready,
    output logic [ID_W-1:0]   axi_arid,
    output logic [ADDR_W-1:0] axi_araddr,
    output logic [7:0]        axi_arlen,
    output logic [2:0]        axi_arsize,
    output logic [1:0]        axi_arburst,
    input  logic              axi_rvalid,
    output logic              axi_rready,
    input  logic [ID_W-1:0]   axi_rid,
    input  logic [DATA_W-1:0] axi_rdata,
    input  logic [1:0]        axi_rresp,
    input  logic              axi_rlast,
    output logic [1:0]        grant_o,
    output logic              busy_o
);

    arb_state_e state_q, state_d;
    logic [1:0] grant_q, grant_d;
    logic [1:0] pick;
    logic       pick_en;
    logic       gnt_arvalid;
    logic       gnt_rready;

    // Routing is by grant only; the returned ID is intentionally ignored.
    logic unused_rid;
    assign unused_rid = ^axi_rid;

    assign pick_en     = (state_q == ST_IDLE) && (if_arvalid || mem_arvalid);
    assign axi_arburst = INCR;
    assign grant_o     = grant_q;
    assign busy_o      = (state_q != ST_IDLE);

    rd_arb_pick #(
        .STARVE_MAX(STARVE_MAX)
    ) u_pick (
        .clk      (clk),
        .rst_n    (rst_n),
        .if_req_i (if_arvalid),
        .mem_req_i(mem_arvalid),
        .pick_en_i(pick_en),
        .pick_o   (pick)
    );

    // State and grant registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            grant_q <= GNT_NONE;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
        end
    end

    // Next state plus AR/R steering toward the registered owner.
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        gnt_arvalid = 1'b0;
        gnt_rready  = 1'b0;
        axi_arvalid = 1'b0;
        axi_arid    = '0;
        axi_araddr  = '0;
        axi_arlen   = '0;
        axi_arsize  = '0;
        axi_rready  = 1'b0;
        if_arready  = 1'b0;
        mem_arready = 1'b0;
        if_rvalid   = 1'b0;
        if_rdata    = '0;
        if_rresp    = '0;
        if_rlast    = 1'b0;
        mem_rvalid  = 1'b0;
        mem_rdata   = '0;
        mem_rresp   = '0;
        mem_rlast   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pick_en) begin
                    grant_d = pick;
                    state_d = ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (grant_q == GNT_IF) begin
                    gnt_arvalid = if_arvalid;
                    axi_arid    = ID_W'(IF_ID);
                    axi_araddr  = if_araddr;
                    axi_arlen   = if_arlen;
                    axi_arsize  = if_arsize;
                    if_arready  = axi_arready;
                end else begin
                    gnt_arvalid = mem_arvalid;
                    axi_arid    = ID_W'(MEM_ID);
                    axi_araddr  = mem_araddr;
                    axi_arlen   = mem_arlen;
                    axi_arsize  = mem_arsize;
                    mem_arready = axi_arready;
                end
                axi_arvalid = gnt_arvalid;
                if (!gnt_arvalid) begin
                    // Requester withdrew before the handshake: give up the bus.
                    state_d = ST_IDLE;
                    grant_d = GNT_NONE;
                end else if (axi_arready) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (grant_q == GNT_IF) begin
                    if_rvalid  = axi_rvalid;
                    if_rdata   = axi_rdata;
                    if_rresp   = axi_rresp;
                    if_rlast   = axi_rlast;
                    gnt_rready = if_rready;
                end else begin
                    mem_rvalid = axi_rvalid;
                    mem_rdata  = axi_rdata;
                    mem_rresp  = axi_rresp;
                    mem_rlast  = axi_rlast;
                    gnt_rready = mem_rready;
                end
                axi_rready = gnt_rready;
                if (axi_rvalid && gnt_rready && axi_rlast) begin
                    state_d = ST_IDLE;
                    grant_d = GNT_NONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = GNT_NONE;
            end
        endcase
    end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Directed bench for axi_rd_arbiter: reset values, contention order (either
// policy, chosen by AXI_RD_ARB_RR_EN), single IF burst, RLAST/new-request
// overlap, AR withdrawal, 4-beat MEM burst with backpressure, AR stall, and
// asynchronous reset in the middle of a burst.
module tb_axi_rd_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        if_arvalid = 0, if_arready;
    logic [63:0] if_araddr = 0;
    logic [7:0]  if_arlen = 0;
    logic [2:0]  if_arsize = 0;
    logic        if_rvalid, if_rready = 0;
    logic [63:0] if_rdata;
    logic [1:0]  if_rresp;
    logic        if_rlast;
    logic        mem_arvalid = 0, mem_arready;
    logic [63:0] mem_araddr = 0;
    logic [7:0]  mem_arlen = 0;
    logic [2:0]  mem_arsize = 0;
    logic        mem_rvalid, mem_rready = 0;
    logic [63:0] mem_rdata;
    logic [1:0]  mem_rresp;
    logic        mem_rlast;
    logic        axi_arvalid, axi_arready = 0;
    logic [3:0]  axi_arid;
    logic [63:0] axi_araddr;
    logic [7:0]  axi_arlen;
    logic [2:0]  axi_arsize;
    logic [1:0]  axi_arburst;
    logic        axi_rvalid = 0, axi_rready;
    logic [3:0]  axi_rid = 0;
    logic [63:0] axi_rdata = 0;
    logic [1:0]  axi_rresp = 0;
    logic        axi_rlast = 0;
    logic [1:0]  grant_o;
    logic        busy_o;

    int errors = 0;
    int checks = 0;

    axi_rd_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .if_arvalid(if_arvalid), .if_arready(if_arready), .if_araddr(if_araddr),
        .if_arlen(if_arlen), .if_arsize(if_arsize), .if_rvalid(if_rvalid),
        .if_rready(if_rready), .if_rdata(if_rdata), .if_rresp(if_rresp), .if_rlast(if_rlast),
        .mem_arvalid(mem_arvalid), .mem_arready(mem_arready), .mem_araddr(mem_araddr),
        .mem_arlen(mem_arlen), .mem_arsize(mem_arsize), .mem_rvalid(mem_rvalid),
        .mem_rready(mem_rready), .mem_rdata(mem_rdata), .mem_rresp(mem_rresp), .mem_rlast(mem_rlast),
        .axi_arvalid(axi_arvalid), .axi_arready(axi_arready), .axi_arid(axi_arid),
        .axi_araddr(axi_araddr), .axi_arlen(axi_arlen), .axi_arsize(axi_arsize),
        .axi_arburst(axi_arburst), .axi_rvalid(axi_rvalid), .axi_rready(axi_rready),
        .axi_rid(axi_rid), .axi_rdata(axi_rdata), .axi_rresp(axi_rresp), .axi_rlast(axi_rlast),
        .grant_o(grant_o), .busy_o(busy_o)
    );

    // Clock.
    always #5 clk = ~clk;

    // Safety net in case the sequence ever stops advancing.
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "bench timeout");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs are driven here.
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    logic [1:0]  exp_gnt [6];
    logic [3:0]  exp_id;
    logic [63:0] b_data [6];
    logic        b_last [6];
    logic        b_rdy  [6];
    int          beats;

    initial begin
`ifdef AXI_RD_ARB_RR_EN
        exp_gnt = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10};
`else
        exp_gnt = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b10};
`endif
        b_data = '{64'hA0, 64'hA1, 64'hA1, 64'hA2, 64'hA3, 64'hA3};
        b_last = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        b_rdy  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

        // Reset values.
        #3;
        chk("rst_busy", busy_o, 0);
        chk("rst_grant", grant_o, 0);
        chk("rst_axi_arvalid", axi_arvalid, 0);
        chk("rst_axi_arid", axi_arid, 0);
        chk("rst_axi_araddr", axi_araddr, 0);
        chk("rst_axi_rready", axi_rready, 0);
        chk("rst_if_arready", if_arready, 0);
        chk("rst_mem_rvalid", mem_rvalid, 0);
        chk("rst_arburst", axi_arburst, 2'b01);
        cyc();
        cyc();
        rst_n = 1'b1;

        // Both masters request every burst.
        if_arvalid = 1; if_araddr = 64'h100;
        mem_arvalid = 1; mem_araddr = 64'h200;
        axi_arready = 1; if_rready = 1; mem_rready = 1;
        for (int r = 0; r < 6; r++) begin
            cyc();
            #1;
            exp_id = (exp_gnt[r] == 2'b01) ? 4'd0 : 4'd1;
            chk("cont_grant", grant_o, exp_gnt[r]);
            chk("cont_arid", axi_arid, exp_id);
            chk("cont_araddr", axi_araddr, (exp_gnt[r] == 2'b01) ? 64'h100 : 64'h200);
            cyc();
            axi_rvalid = 1; axi_rlast = 1; axi_rdata = 64'hA0 + 64'(r);
            #1;
            chk("cont_if_rvalid", if_rvalid, exp_gnt[r] == 2'b01);
            chk("cont_mem_rvalid", mem_rvalid, exp_gnt[r] == 2'b10);
            cyc();
            axi_rvalid = 0; axi_rlast = 0;
            #1;
            chk("cont_idle", busy_o, 0);
        end
        if_arvalid = 0; mem_arvalid = 0;

        // IF-only single beat, with a MEM request arriving on the RLAST beat.
        cyc();
        if_arvalid = 1; if_araddr = 64'h8000_0000; if_arlen = 0; if_arsize = 3;
        #1;
        chk("if_no_fwd_idle", axi_arvalid, 0);
        cyc();
        #1;
        chk("if_axi_arvalid", axi_arvalid, 1);
        chk("if_axi_arid", axi_arid, 0);
        chk("if_axi_araddr", axi_araddr, 64'h8000_0000);
        chk("if_axi_arlen", axi_arlen, 0);
        chk("if_arready", if_arready, 1);
        chk("if_mem_arready", mem_arready, 0);
        chk("if_grant", grant_o, 2'b01);
        cyc();
        if_arvalid = 0; axi_arready = 0;
        axi_rvalid = 1; axi_rdata = 64'h1234; axi_rlast = 1; axi_rresp = 0;
        mem_arvalid = 1; mem_araddr = 64'h4000;
        #1;
        chk("if_rvalid", if_rvalid, 1);
        chk("if_rdata", if_rdata, 64'h1234);
        chk("if_rlast", if_rlast, 1);
        chk("if_mem_rvalid", mem_rvalid, 0);
        chk("if_axi_rready", axi_rready, 1);
        cyc();
        axi_rvalid = 0; axi_rlast = 0;
        #1;
        chk("rlast_overlap_busy", busy_o, 0);
        chk("rlast_overlap_grant", grant_o, 0);
        cyc();
        #1;
        chk("late_grant_mem", grant_o, 2'b10);
        chk("late_araddr", axi_araddr, 64'h4000);
        mem_arvalid = 0;
        #1;
        chk("abort_arvalid", axi_arvalid, 0);
        cyc();
        #1;
        chk("abort_busy", busy_o, 0);
        chk("abort_grant", grant_o, 0);

        // 4-beat MEM burst with mem_rready backpressure.
        mem_arvalid = 1; mem_araddr = 64'h1000; mem_arlen = 3; axi_arready = 1;
        cyc();
        #1;
        chk("m4_arlen", axi_arlen, 3);
        chk("m4_arid", axi_arid, 1);
        chk("m4_mem_arready", mem_arready, 1);
        chk("m4_if_arready", if_arready, 0);
        cyc();
        mem_arvalid = 0; axi_arready = 0;
        beats = 0;
        for (int s = 0; s < 6; s++) begin
            axi_rvalid = 1; axi_rdata = b_data[s]; axi_rlast = b_last[s]; mem_rready = b_rdy[s];
            #1;
            chk("m4_axi_rready", axi_rready, b_rdy[s]);
            chk("m4_mem_rdata", mem_rdata, b_data[s]);
            chk("m4_mem_rlast", mem_rlast, b_last[s]);
            chk("m4_if_rvalid", if_rvalid, 0);
            chk("m4_busy", busy_o, 1);
            if (mem_rvalid && mem_rready) beats++;
            cyc();
        end
        axi_rvalid = 0; axi_rlast = 0; mem_rready = 1;
        #1;
        chk("m4_beats", 64'(beats), 4);
        chk("m4_idle", busy_o, 0);

        // AR stall for 5 cycles.
        if_arvalid = 1; if_araddr = 64'h2000_0040; if_arlen = 3; axi_arready = 0;
        cyc();
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("stall_if_arready", if_arready, 0);
            chk("stall_mem_arready", mem_arready, 0);
            chk("stall_arvalid", axi_arvalid, 1);
            chk("stall_araddr", axi_araddr, 64'h2000_0040);
            cyc();
        end
        axi_arready = 1;
        #1;
        chk("stall_release", if_arready, 1);
        cyc();
        if_arvalid = 0; axi_arready = 0;

        // Reset during beat 2 of a 4-beat IF burst.
        for (int b = 0; b < 2; b++) begin
            axi_rvalid = 1; axi_rdata = 64'hB0 + 64'(b); axi_rlast = 0;
            #1;
            chk("rb_if_rvalid", if_rvalid, 1);
            cyc();
        end
        axi_rdata = 64'hB2;
        #1;
        chk("rb_beat2", if_rdata, 64'hB2);
        rst_n = 0;
        #1;
        chk("rb_busy", busy_o, 0);
        chk("rb_grant", grant_o, 0);
        chk("rb_if_rvalid0", if_rvalid, 0);
        chk("rb_if_rdata0", if_rdata, 0);
        chk("rb_axi_rready", axi_rready, 0);
        chk("rb_axi_arvalid", axi_arvalid, 0);
        axi_rvalid = 0;
        cyc();
        rst_n = 1;
        if_arvalid = 1; if_araddr = 64'h3000; if_arlen = 0; axi_arready = 1;
        cyc();
        #1;
        chk("post_rst_grant", grant_o, 2'b01);
        chk("post_rst_arid", axi_arid, 0);
        chk("post_rst_araddr", axi_araddr, 64'h3000);
        cyc();
        if_arvalid = 0; axi_arready = 0;
        axi_rvalid = 1; axi_rlast = 1; axi_rdata = 64'h55;
        #1;
        chk("post_rst_rdata", if_rdata, 64'h55);
        cyc();
        axi_rvalid = 0; axi_rlast = 0;
        #1;
        chk("post_rst_idle", busy_o, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
